pio_fifo_pair: RTL and testbench

- Parametrised TX/RX FIFO pair for one PIO state machine. It supersedes the two fixed, independent fifo instances inside the PIO core.
- Adds runtime join modes that re-assign one shared storage array:
  - both directions at DEPTH entries each, or
  - one direction at 2*DEPTH entries with the other disabled.
- Also adds sticky overflow/underflow flags.
- Sits between the system-side data interface and the PIO fsm.
- TX direction: system pushes, fsm pops. RX direction: fsm pushes, system pops.

---
 rtl/pio_pkg.sv | 28 ++
 rtl/pio_fifo_pair_if.sv | 39 +++
 rtl/pio_fifo_ctrl.sv | 70 +++++++
 rtl/pio_fifo_pair.sv | 135 +++++++++++++
 tb/tb_pio_fifo_pair.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/pio_pkg.sv
// Shared types and bit indices for the PIO TX/RX FIFO pair.
// Imported by the FIFO controller, the FIFO pair top level and its testbench.
package pio_pkg;

    typedef enum logic [1:0] {
        JOIN_NONE = 2'b00,
        JOIN_TX   = 2'b01,
        JOIN_RX   = 2'b10
    } join_mode_e;

    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;

    localparam int TX_OVF = 0;
    localparam int TX_UDF = 1;
    localparam int RX_OVF = 2;
    localparam int RX_UDF = 3;

    // The reserved encoding 2'b11 behaves exactly like JOIN_NONE.
    function automatic join_mode_e decode_join(input logic [1:0] raw);
        case (raw)
            2'b01:   return JOIN_TX;
            2'b10:   return JOIN_RX;
            default: return JOIN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/pio_fifo_pair_if.sv
// Data/handshake bundle between the system side, the PIO fsm and the FIFO pair.
// master drives pushes/pops and control; slave is the FIFO pair itself.
interface pio_fifo_pair_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(2 * DEPTH + 1);

    logic [1:0]        join_mode;
    logic              tx_push_en;
    logic [DATA_W-1:0] tx_data_in;
    logic              tx_pop_en;
    logic [DATA_W-1:0] tx_data_out;
    logic [1:0]        tx_status;
    logic [CNT_W-1:0]  tx_count;
    logic              rx_push_en;
    logic [DATA_W-1:0] rx_data_in;
    logic              rx_pop_en;
    logic [DATA_W-1:0] rx_data_out;
    logic [1:0]        rx_status;
    logic [CNT_W-1:0]  rx_count;
    logic [3:0]        flag_clr;
    logic [3:0]        flags;

    modport master (
        output join_mode, tx_push_en, tx_data_in, tx_pop_en,
               rx_push_en, rx_data_in, rx_pop_en, flag_clr,
        input  tx_data_out, tx_status, tx_count,
               rx_data_out, rx_status, rx_count, flags
    );

    modport slave (
        input  join_mode, tx_push_en, tx_data_in, tx_pop_en,
               rx_push_en, rx_data_in, rx_pop_en, flag_clr,
        output tx_data_out, tx_status, tx_count,
               rx_data_out, rx_status, rx_count, flags
    );

endinterface

// File: rtl/pio_fifo_ctrl.sv
// Pointer/occupancy controller for one FIFO direction inside a shared array.
// Capacity and base offset are runtime inputs so the region can be re-assigned.
module pio_fifo_ctrl #(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(2 * DEPTH + 1),
    localparam int AW    = $clog2(2 * DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] capacity,
    input  logic [CNT_W-1:0] base,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    output logic [AW-1:0]    rd_addr,
    output logic [AW-1:0]    wr_addr,
    output logic             wr_en,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             udf
);

    logic [CNT_W-1:0] rd_ptr;
    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;
    logic             pop_ok;
    logic             push_ok;

    // Explicit wrap at capacity-1 so any capacity works, not only powers of two.
    function automatic logic [CNT_W-1:0] next_ptr(input logic [CNT_W-1:0] p,
                                                  input logic [CNT_W-1:0] cap);
        return (p == cap - CNT_W'(1)) ? '0 : p + CNT_W'(1);
    endfunction

    assign full  = (count_q == capacity);
    assign empty = (count_q == '0);

    // A pop frees a slot, so a push to a full FIFO is accepted alongside it.
    // A zero-capacity region is both full and empty, so nothing is ever accepted.
    assign pop_ok  = pop  && !flush && !empty;
    assign push_ok = push && !flush && (!full || pop_ok);
    assign ovf     = push && !flush && !push_ok;
    assign udf     = pop  && !flush && empty;

    assign wr_en   = push_ok;
    assign count   = count_q;
    assign rd_addr = AW'(base + rd_ptr);
    assign wr_addr = AW'(base + wr_ptr);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= next_ptr(wr_ptr, capacity);
            if (pop_ok)  rd_ptr <= next_ptr(rd_ptr, capacity);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/pio_fifo_pair.sv
// TX/RX FIFO pair for one PIO state machine sharing a single 2*DEPTH array,
// with runtime join modes and sticky overflow/underflow flags.
module pio_fifo_pair
    import pio_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input logic              clk,
    input logic              rst,
    pio_fifo_pair_if.slave   bus
);

    localparam int CNT_W = $clog2(2 * DEPTH + 1);
    localparam int AW    = $clog2(2 * DEPTH);

    join_mode_e       mode_q;
    join_mode_e       mode_req;
    logic             mode_chg;

    logic [CNT_W-1:0] tx_cap;
    logic [CNT_W-1:0] tx_base;
    logic [CNT_W-1:0] rx_cap;
    logic [CNT_W-1:0] rx_base;

    logic [AW-1:0]    tx_rd_addr, tx_wr_addr, rx_rd_addr, rx_wr_addr;
    logic             tx_wr_en, rx_wr_en;
    logic [CNT_W-1:0] tx_count, rx_count;
    logic             tx_full, tx_empty, rx_full, rx_empty;
    logic             tx_ovf, tx_udf, rx_ovf, rx_udf;

    logic [3:0]       flags_q;
    logic [3:0]       flag_set;

    logic [DATA_W-1:0] mem [2*DEPTH];

    // A mode change flushes both directions and swallows that cycle's traffic.
    assign mode_req = decode_join(bus.join_mode);
    assign mode_chg = (mode_req != mode_q);

    always_ff @(posedge clk) begin
        if (rst)           mode_q <= JOIN_NONE;
        else if (mode_chg) mode_q <= mode_req;
    end

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        tx_cap  = CNT_W'(DEPTH);
        tx_base = '0;
        rx_cap  = CNT_W'(DEPTH);
        rx_base = CNT_W'(DEPTH);
        case (mode_q)
            JOIN_TX: begin
                tx_cap  = CNT_W'(2 * DEPTH);
                rx_cap  = '0;
                rx_base = '0;
            end
            JOIN_RX: begin
                tx_cap  = '0;
                rx_cap  = CNT_W'(2 * DEPTH);
                rx_base = '0;
            end
            default: ;
        endcase
    end

    pio_fifo_ctrl #(.DEPTH(DEPTH)) u_tx_ctrl (
        .clk      (clk),
        .rst      (rst),
        .capacity (tx_cap),
        .base     (tx_base),
        .push     (bus.tx_push_en),
        .pop      (bus.tx_pop_en),
        .flush    (mode_chg),
        .rd_addr  (tx_rd_addr),
        .wr_addr  (tx_wr_addr),
        .wr_en    (tx_wr_en),
        .count    (tx_count),
        .full     (tx_full),
        .empty    (tx_empty),
        .ovf      (tx_ovf),
        .udf      (tx_udf)
    );

    pio_fifo_ctrl #(.DEPTH(DEPTH)) u_rx_ctrl (
        .clk      (clk),
        .rst      (rst),
        .capacity (rx_cap),
        .base     (rx_base),
        .push     (bus.rx_push_en),
        .pop      (bus.rx_pop_en),
        .flush    (mode_chg),
        .rd_addr  (rx_rd_addr),
        .wr_addr  (rx_wr_addr),
        .wr_en    (rx_wr_en),
        .count    (rx_count),
        .full     (rx_full),
        .empty    (rx_empty),
        .ovf      (rx_ovf),
        .udf      (rx_udf)
    );

    // NOTE: the storage array has no reset; stale entries are never visible
    // because the read port is forced to zero whenever a direction is empty.
    always_ff @(posedge clk) begin
        if (tx_wr_en) mem[tx_wr_addr] <= bus.tx_data_in;
        if (rx_wr_en) mem[rx_wr_addr] <= bus.rx_data_in;
    end

    always_comb begin
        flag_set         = '0;
        flag_set[TX_OVF] = tx_ovf;
        flag_set[TX_UDF] = tx_udf;
        flag_set[RX_OVF] = rx_ovf;
        flag_set[RX_UDF] = rx_udf;
    end

    // Set is OR-ed after the clear so a same-cycle set wins.
    always_ff @(posedge clk) begin
        if (rst) flags_q <= '0;
        else     flags_q <= (flags_q & ~bus.flag_clr) | flag_set;
    end

    assign bus.tx_data_out           = tx_empty ? '0 : mem[tx_rd_addr];
    assign bus.rx_data_out           = rx_empty ? '0 : mem[rx_rd_addr];
    assign bus.tx_status[STAT_FULL]  = tx_full;
    assign bus.tx_status[STAT_EMPTY] = tx_empty;
    assign bus.rx_status[STAT_FULL]  = rx_full;
    assign bus.rx_status[STAT_EMPTY] = rx_empty;
    assign bus.tx_count              = tx_count;
    assign bus.rx_count              = rx_count;
    assign bus.flags                 = flags_q;

endmodule

// File: tb/tb_pio_fifo_pair.sv
// Self-checking bench for pio_fifo_pair: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_pio_fifo_pair;
    import pio_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pio_fifo_pair_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    pio_fifo_pair #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: plain queues and a mode number (0 none, 1 tx, 2 rx).
    logic [DATA_W-1:0] m_tx[$];
    logic [DATA_W-1:0] m_rx[$];
    int                m_mode  = 0;
    logic [3:0]        m_flags = '0;
    logic [1:0]        jm_cur  = 2'b00;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int cap_of(input int mode, input bit is_tx);
        if (mode == 0) return DEPTH;
        if (mode == 1) return is_tx ? 2 * DEPTH : 0;
        return is_tx ? 0 : 2 * DEPTH;
    endfunction

    task automatic compare_model();
        int tc = cap_of(m_mode, 1'b1);
        int rc = cap_of(m_mode, 1'b0);
        check("tx_count",  64'(bus.tx_count), 64'(m_tx.size()));
        check("tx_status", 64'(bus.tx_status), {62'd0, m_tx.size() == tc, m_tx.size() == 0});
        check("tx_data",   64'(bus.tx_data_out), (m_tx.size() > 0) ? 64'(m_tx[0]) : 64'd0);
        check("rx_count",  64'(bus.rx_count), 64'(m_rx.size()));
        check("rx_status", 64'(bus.rx_status), {62'd0, m_rx.size() == rc, m_rx.size() == 0});
        check("rx_data",   64'(bus.rx_data_out), (m_rx.size() > 0) ? 64'(m_rx[0]) : 64'd0);
        check("flags",     64'(bus.flags), 64'(m_flags));
    endtask

    // One clock: drive at negedge, advance the model, check #1 after posedge.
    task automatic step(input logic [1:0] jm, input bit tp, input logic [DATA_W-1:0] td,
                        input bit tpop, input bit rp, input logic [DATA_W-1:0] rd,
                        input bit rpop, input logic [3:0] clr, input bit r);
        int         req;
        logic [3:0] set;
        bit         t_pop_ok, r_pop_ok, t_acc, r_acc;
        @(negedge clk);
        bus.join_mode  = jm;
        bus.tx_push_en = tp;
        bus.tx_data_in = td;
        bus.tx_pop_en  = tpop;
        bus.rx_push_en = rp;
        bus.rx_data_in = rd;
        bus.rx_pop_en  = rpop;
        bus.flag_clr   = clr;
        rst            = r;

        req = (jm == 2'b01) ? 1 : (jm == 2'b10) ? 2 : 0;
        if (r) begin
            m_tx.delete();
            m_rx.delete();
            m_mode  = 0;
            m_flags = '0;
        end else if (req != m_mode) begin
            m_tx.delete();
            m_rx.delete();
            m_mode  = req;
            m_flags = m_flags & ~clr;
        end else begin
            set      = '0;
            t_pop_ok = tpop && (m_tx.size() > 0);
            r_pop_ok = rpop && (m_rx.size() > 0);
            t_acc    = tp && ((m_tx.size() < cap_of(m_mode, 1'b1)) || t_pop_ok);
            r_acc    = rp && ((m_rx.size() < cap_of(m_mode, 1'b0)) || r_pop_ok);
            set[0]   = tp && !t_acc;
            set[1]   = tpop && (m_tx.size() == 0);
            set[2]   = rp && !r_acc;
            set[3]   = rpop && (m_rx.size() == 0);
            if (t_pop_ok) void'(m_tx.pop_front());
            if (r_pop_ok) void'(m_rx.pop_front());
            if (t_acc)    m_tx.push_back(td);
            if (r_acc)    m_rx.push_back(rd);
            m_flags = (m_flags & ~clr) | set;
        end

        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic idle(input logic [3:0] clr);
        step(jm_cur, 0, '0, 0, 0, '0, 0, clr, 0);
    endtask
    task automatic tx_push(input logic [DATA_W-1:0] d);
        step(jm_cur, 1, d, 0, 0, '0, 0, 4'b0, 0);
    endtask
    task automatic tx_pop();
        step(jm_cur, 0, '0, 1, 0, '0, 0, 4'b0, 0);
    endtask
    task automatic rx_push(input logic [DATA_W-1:0] d);
        step(jm_cur, 0, '0, 0, 1, d, 0, 4'b0, 0);
    endtask
    task automatic rx_pop();
        step(jm_cur, 0, '0, 0, 0, '0, 1, 4'b0, 0);
    endtask

    initial begin
        logic [DATA_W-1:0] exp_tx [4];
        int bias;

        // Reset state
        step(2'b00, 0, '0, 0, 0, '0, 0, 4'b0, 1);
        check("rst_tx_status", 64'(bus.tx_status), 64'h1);
        check("rst_rx_status", 64'(bus.rx_status), 64'h1);
        check("rst_flags",     64'(bus.flags), 64'h0);
        check("rst_tx_data",   64'(bus.tx_data_out), 64'h0);

        // Fill TX in NONE mode, overflow, drain in order
        exp_tx = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int i = 0; i < 4; i++) tx_push(exp_tx[i]);
        check("fill_count",  64'(bus.tx_count), 64'd4);
        check("fill_status", 64'(bus.tx_status), 64'h2);
        check("fill_head",   64'(bus.tx_data_out), 64'h11);
        tx_push(32'h55);
        check("tx_ovf", 64'(bus.flags[TX_OVF]), 64'd1);
        for (int i = 0; i < 4; i++) begin
            check("drain_head", 64'(bus.tx_data_out), 64'(exp_tx[i]));
            tx_pop();
        end
        check("drain_status", 64'(bus.tx_status), 64'h1);
        idle(4'hF);
        check("clr_all", 64'(bus.flags), 64'h0);

        // RX wrap-around with alternating push/pop
        for (int i = 0; i < 10; i++) begin
            rx_push(32'hA0 + DATA_W'(i));
            check("wrap_cnt1", 64'(bus.rx_count), 64'd1);
            check("wrap_data", 64'(bus.rx_data_out), 64'(32'hA0 + i));
            rx_pop();
            check("wrap_cnt0", 64'(bus.rx_count), 64'd0);
        end
        check("wrap_flags", 64'(bus.flags), 64'h0);

        // Full TX with simultaneous push+pop
        for (int i = 1; i <= 4; i++) tx_push(DATA_W'(i));
        step(jm_cur, 1, 32'h99, 1, 0, '0, 0, 4'b0, 0);
        check("pp_count", 64'(bus.tx_count), 64'd4);
        check("pp_head",  64'(bus.tx_data_out), 64'h2);
        check("pp_noovf", 64'(bus.flags[TX_OVF]), 64'd0);
        for (int i = 0; i < 3; i++) tx_pop();
        check("pp_fourth", 64'(bus.tx_data_out), 64'h99);
        tx_pop();

        // Empty RX with simultaneous push+pop: udf set, push kept
        step(jm_cur, 0, '0, 0, 1, 32'h5A, 1, 4'b0, 0);
        check("udf_flag",  64'(bus.flags[RX_UDF]), 64'd1);
        check("udf_count", 64'(bus.rx_count), 64'd1);
        check("udf_data",  64'(bus.rx_data_out), 64'h5A);
        idle(4'b1000);
        check("udf_clr", 64'(bus.flags[RX_UDF]), 64'd0);
        rx_pop();

        // Switch to JOIN_TX: flush, push in the switch cycle is dropped
        tx_push(32'hC1);
        tx_push(32'hC2);
        jm_cur = 2'b01;
        step(jm_cur, 1, 32'hC3, 0, 0, '0, 0, 4'b0, 0);
        check("join_flush", 64'(bus.tx_count), 64'd0);
        check("join_rx_st", 64'(bus.rx_status), 64'h3);
        for (int i = 0; i < 2 * DEPTH; i++) tx_push(32'hD0 + DATA_W'(i));
        check("join_count",  64'(bus.tx_count), 64'd8);
        check("join_status", 64'(bus.tx_status), 64'h2);
        rx_push(32'hEE);
        check("join_rx_ovf", 64'(bus.flags[RX_OVF]), 64'd1);
        for (int i = 0; i < 5; i++) tx_pop();
        check("join_three", 64'(bus.tx_count), 64'd3);

        // Reset mid-traffic
        step(jm_cur, 0, '0, 0, 0, '0, 0, 4'b0, 1);
        check("mid_rst_tx", 64'(bus.tx_status), 64'h1);
        check("mid_rst_rx", 64'(bus.rx_status), 64'h1);
        check("mid_rst_fl", 64'(bus.flags), 64'h0);
        jm_cur = 2'b00;
        idle(4'b0);

        // Random traffic against the model
        bias = 50;
        for (int n = 0; n < 4000; n++) begin
            if (n % 200 == 0) bias = $urandom_range(15, 85);
            if ($urandom_range(0, 59) == 0) jm_cur = 2'($urandom_range(0, 3));
            step(jm_cur,
                 $urandom_range(0, 99) < bias, $urandom,
                 $urandom_range(0, 99) >= bias,
                 $urandom_range(0, 99) >= bias, $urandom,
                 $urandom_range(0, 99) < bias,
                 ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0,
                 $urandom_range(0, 499) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
